// File: rtl/hex_pkg.sv
// Shared types and constants for the hex editor and the seven-segment display driver.
package hex_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int NIBBLE_W   = 4;
    localparam int NUM_BTNS   = 3;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_WRITE = 2;

    typedef logic [NUM_DIGITS*NIBBLE_W-1:0] hex_word_t;
    typedef logic [$clog2(NUM_DIGITS)-1:0]  digit_idx_t;

    typedef enum logic [1:0] {ACT_NONE, ACT_WRITE, ACT_LEFT, ACT_RIGHT} action_t;

    // Coincident presses: write wins over left, left over right; losers are dropped.
    function automatic action_t pick_action(input logic [NUM_BTNS-1:0] press);
        if (press[BTN_WRITE])      return ACT_WRITE;
        else if (press[BTN_LEFT])  return ACT_LEFT;
        else if (press[BTN_RIGHT]) return ACT_RIGHT;
        else                       return ACT_NONE;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for one active-low button;
// emits a one-cycle press_o pulse on an accepted release->press transition.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic nrst_i,
    input  logic nbtn_i,
    output logic press_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;

    // The change is accepted on the cycle the count would reach N, so press_o
    // rises exactly N cycles after the synchroniser output changes.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_o  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], nbtn_i};
            press_o <= 1'b0;
            if (sync_q[1] == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_q <= sync_q[1];
                cnt_q    <= '0;
                press_o  <= stable_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hex_editor.sv
// Button-driven nibble editor feeding the seven-segment driver.
// Cursor blinking is built only when HEX_EDITOR_BLINK_EN is defined.
module hex_editor
    import hex_pkg::*;
#(
    parameter int        DEBOUNCE_CYCLES = 4,
    parameter int        BLINK_CYCLES    = 8,
    parameter hex_word_t INIT_VALUE      = '0
) (
    input  logic                  clk_i,
    input  logic                  nrst_i,
    input  logic [NUM_BTNS-1:0]   nbtn_i,
    input  logic [NIBBLE_W-1:0]   sw_i,
    output hex_word_t             data_o,
    output digit_idx_t            cursor_o,
    output logic [NUM_DIGITS-1:0] dig_en_o
);

    logic [NUM_BTNS-1:0] press;
    action_t             act;
    hex_word_t           data_d;
    digit_idx_t          cursor_d;
    logic                move;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn [NUM_BTNS-1:0] (
        .clk_i   (clk_i),
        .nrst_i  (nrst_i),
        .nbtn_i  (nbtn_i),
        .press_o (press)
    );

    always_comb begin
        act      = pick_action(press);
        data_d   = data_o;
        cursor_d = cursor_o;
        move     = 1'b0;
        case (act)
            ACT_WRITE: data_d[int'(cursor_o)*NIBBLE_W +: NIBBLE_W] = sw_i;
            ACT_LEFT:  begin cursor_d = cursor_o + digit_idx_t'(1); move = 1'b1; end
            ACT_RIGHT: begin cursor_d = cursor_o - digit_idx_t'(1); move = 1'b1; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            data_o   <= INIT_VALUE;
            cursor_o <= '0;
        end else begin
            data_o   <= data_d;
            cursor_o <= cursor_d;
        end
    end

`ifdef HEX_EDITOR_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_CYCLES > 1 ? BLINK_CYCLES : 2);

    logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic                  phase_q, phase_d;
    logic [NUM_DIGITS-1:0] dig_en_d;

    // A cursor move restarts the blink so the newly selected digit is lit at once.
    always_comb begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        phase_d     = phase_q;
        if (move) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
        dig_en_d = phase_d ? ~(NUM_DIGITS'(1) << cursor_d) : '1;
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            dig_en_o    <= '1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            dig_en_o    <= dig_en_d;
        end
    end
`else
    assign dig_en_o = '1;
`endif

endmodule

// File: tb/tb_hex_editor.sv
// Scoreboard bench for hex_editor: each press queues its expected data/cursor
// and arrival cycle; a negedge monitor pops and compares on every output change.
module tb_hex_editor;
    import hex_pkg::*;

    localparam int N   = 4;
    localparam int LAT = N + 3;

    logic                  clk = 1'b0;
    logic                  nrst_i = 1'b0;
    logic [NUM_BTNS-1:0]   nbtn = '1;
    logic [NIBBLE_W-1:0]   sw = '0;
    hex_word_t             data;
    digit_idx_t            cursor;
    logic [NUM_DIGITS-1:0] dig_en;

    hex_editor #(.DEBOUNCE_CYCLES(N), .BLINK_CYCLES(8), .INIT_VALUE(32'h0)) dut (
        .clk_i    (clk),
        .nrst_i   (nrst_i),
        .nbtn_i   (nbtn),
        .sw_i     (sw),
        .data_o   (data),
        .cursor_o (cursor),
        .dig_en_o (dig_en)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        hex_word_t  data;
        digit_idx_t cur;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    hex_word_t  m_data = '0;
    digit_idx_t m_cur  = '0;

    logic [34:0] prev = '0;
    always @(negedge clk) begin
        if (nrst_i && ({data, cursor} !== prev)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_update: got data=%h cursor=%0d at cyc %0d, required no change", data, cursor, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (data !== e.data || cursor !== e.cur || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL update: got data=%h cursor=%0d cyc=%0d, required data=%h cursor=%0d cyc=%0d",
                             data, cursor, cyc, e.data, e.cur, e.cyc);
                end
            end
        end
        prev = {data, cursor};
    end

    // Drive a press of the buttons in mask and queue the resulting state.
    task automatic drive_press(input logic [NUM_BTNS-1:0] mask, input logic [NIBBLE_W-1:0] nib);
        exp_t e;
        @(posedge clk); #1;
        sw = nib;
        if (mask[BTN_WRITE])      m_data[4*m_cur +: 4] = nib;
        else if (mask[BTN_LEFT])  m_cur = m_cur + 3'd1;
        else if (mask[BTN_RIGHT]) m_cur = m_cur - 3'd1;
        nbtn = nbtn & ~mask;
        e.data = m_data; e.cur = m_cur; e.cyc = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic release_btns();
        @(posedge clk); #1;
        nbtn = '1;
        repeat (12) @(posedge clk);
    endtask

    task automatic do_press(input logic [NUM_BTNS-1:0] mask, input logic [NIBBLE_W-1:0] nib);
        drive_press(mask, nib);
        repeat (10) @(posedge clk);
        release_btns();
    endtask

    task automatic test_reset();
        nrst_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 3;
        if (data !== 32'h0)    begin errors++; $display("FAIL reset_data: got %h required 00000000", data); end
        if (cursor !== 3'd0)   begin errors++; $display("FAIL reset_cursor: got %0d required 0", cursor); end
        if (dig_en !== 8'hFF)  begin errors++; $display("FAIL reset_dig_en: got %h required ff", dig_en); end
        nrst_i = 1'b1;
        // Reset mid-count must discard the partially debounced press.
        repeat (2) @(posedge clk); #1;
        nbtn[BTN_WRITE] = 1'b0; sw = 4'h9;
        repeat (4) @(posedge clk); #1;
        nrst_i = 1'b0;
        nbtn = '1;
        repeat (3) @(posedge clk); #1;
        nrst_i = 1'b1;
        repeat (15) @(posedge clk); #1;
        checks++;
        if (data !== 32'h0) begin errors++; $display("FAIL reset_discard: got %h required 00000000", data); end
    endtask

    task automatic test_write();
        do_press(3'b100, 4'hA);
        checks++;
        if (data !== 32'h0000000A || cursor !== 3'd0) begin
            errors++; $display("FAIL write: got %h/%0d required 0000000a/0", data, cursor);
        end
    endtask

    task automatic test_bounce();
        sw = 4'h7;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1; nbtn[BTN_WRITE] = 1'b0;
            repeat (2) @(posedge clk); #1; nbtn[BTN_WRITE] = 1'b1;
            @(posedge clk);
        end
        repeat (20) @(posedge clk); #1;
        checks++;
        if (data !== 32'h0000000A) begin errors++; $display("FAIL bounce: got %h required 0000000a", data); end
    endtask

    task automatic test_wrap_write();
        for (int i = 0; i < 8; i++) do_press(3'b001, 4'h0);
        checks++;
        if (cursor !== 3'd0) begin errors++; $display("FAIL left_wrap: got %0d required 0", cursor); end
        do_press(3'b010, 4'h0);
        checks++;
        if (cursor !== 3'd7) begin errors++; $display("FAIL right_wrap: got %0d required 7", cursor); end
        do_press(3'b100, 4'h5);
        checks++;
        if (data !== 32'h5000000A) begin errors++; $display("FAIL wrap_write: got %h required 5000000a", data); end
    endtask

    task automatic test_simultaneous();
        do_press(3'b001, 4'h0);
        do_press(3'b101, 4'h3);
        checks++;
        if (data !== 32'h50000003 || cursor !== 3'd0) begin
            errors++; $display("FAIL simultaneous: got %h/%0d required 50000003/0", data, cursor);
        end
    endtask

    task automatic blink_move(input logic [NUM_BTNS-1:0] mask);
        logic [NUM_DIGITS-1:0] exp_en;
        drive_press(mask, 4'h0);
        for (int i = 0; i < 30 && cursor !== m_cur; i++) @(negedge clk);
        checks++;
        if (cursor !== m_cur) begin
            errors++; $display("FAIL blink_move_timeout: got cursor %0d required %0d", cursor, m_cur);
        end
        for (int i = 0; i < 16; i++) begin
`ifdef HEX_EDITOR_BLINK_EN
            exp_en = (i < 8) ? 8'hFF : ~(8'h01 << m_cur);
`else
            exp_en = 8'hFF;
`endif
            checks++;
            if (dig_en !== exp_en) begin
                errors++; $display("FAIL dig_en[%0d]: got %h required %h", i, dig_en, exp_en);
            end
            @(negedge clk);
        end
        release_btns();
    endtask

    task automatic test_blink();
        do_press(3'b001, 4'h0);
        blink_move(3'b001);
        blink_move(3'b010);
    endtask

    task automatic test_held_through_reset();
        exp_t e;
        @(posedge clk); #1;
        nrst_i = 1'b0;
        nbtn[BTN_WRITE] = 1'b0;
        sw = 4'hC;
        repeat (3) @(posedge clk); #1;
        nrst_i = 1'b1;
        m_data = 32'h0000000C; m_cur = '0;
        e.data = m_data; e.cur = m_cur; e.cyc = cyc + LAT;
        sb.push_back(e);
        repeat (10) @(posedge clk);
        release_btns();
    endtask

    initial begin
        test_reset();
        test_write();
        test_bounce();
        test_wrap_write();
        test_simultaneous();
        test_blink();
        test_held_through_reset();
        repeat (20) @(posedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL pending_updates: got %0d outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

endmodule
